// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg -- shared definitions for the pipelined address adder.
//   MODE_W : width of the operation-select field
//   mode_e : operation encoding (value 3 is reserved and behaves as ADD)
package pipe_adder_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD      = 2'd0,
    MODE_SUB      = 2'd1,
    MODE_ADD_SHL2 = 2'd2
  } mode_e;

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if -- valid/ready request and response bundle of pipe_adder.
//   in_valid/in_ready : input handshake
//   in_a, in_b, mode  : operands and operation select
//   flush             : drop everything in flight
//   out_valid/out_ready : result handshake
//   out_sum, out_carry, out_ovf, out_zero : result and flags
// master: the block driving operands and consuming results.
// slave : the adder itself.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [MODE_W-1:0] mode;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_sum;
  logic              out_carry;
  logic              out_ovf;
  logic              out_zero;

  modport master (
    output in_valid, in_a, in_b, mode, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, mode, flush, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );

endinterface

// File: rtl/pipe_adder_seg.sv
// pipe_adder_seg -- one stage of the pipelined adder.
//   Adds slice IDX (SW bits) of the effective operands plus the incoming carry,
//   merges that slice into the partially assembled sum and registers operands,
//   sum, carry-out and valid. Everything holds while adv is low; flush clears
//   the valid bit regardless of adv.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   adv, flush          : pipeline advance / discard
//   in_valid, in_a, in_b, in_sum, in_carry : state from the previous stage
//   valid, a, b, sum, carry                : registered state of this stage
module pipe_adder_seg #(
  parameter int WIDTH = 32,
  parameter int SW    = 16,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int LO = IDX * SW;
  localparam logic [WIDTH-1:0] SLICE_MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;

  logic [SW:0]      slice_add;
  logic [WIDTH-1:0] next_sum;

  // Slice adder; the extra top bit is the carry handed to the next stage.
  assign slice_add = {1'b0, in_a[LO +: SW]} + {1'b0, in_b[LO +: SW]} + {{SW{1'b0}}, in_carry};

  // Lower slices come from earlier stages, this stage fills its own slice.
  assign next_sum = (in_sum & ~SLICE_MASK) | (WIDTH'(slice_add[SW-1:0]) << LO);

  // Stage registers: data loads only on advance; flush wins over advance for valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (adv) begin
        valid <= in_valid;
      end
      if (adv) begin
        a     <= in_a;
        b     <= in_b;
        sum   <= next_sum;
        carry <= slice_add[SW];
      end
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder -- pipelined ADD / SUB / ADD_SHL2 adder with valid/ready handshake.
//   STAGES segments each add WIDTH/STAGES bits; latency is STAGES cycles and
//   one result per cycle is accepted when the output is not stalled.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_adder_if slave (operands, mode, flush, results, flags)
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_adder_if.slave  bus
);

  localparam int SW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  // Index 0 is the stage-0 input, index k+1 the registered output of segment k.
  logic [STAGES:0]  v_c;
  logic [STAGES:0]  c_c;
  logic [WIDTH-1:0] a_c [STAGES+1];
  logic [WIDTH-1:0] b_c [STAGES+1];
  logic [WIDTH-1:0] s_c [STAGES+1];

  assign adv          = !v_c[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  // Effective B operand and carry-in; SUB is A + ~B + 1, reserved mode acts as ADD.
  always_comb begin
    b_eff = bus.in_b;
    cin   = 1'b0;
    case (bus.mode)
      MODE_SUB: begin
        b_eff = ~bus.in_b;
        cin   = 1'b1;
      end
      MODE_ADD_SHL2: begin
        b_eff = {bus.in_b[WIDTH-3:0], 2'b00};
      end
      default: begin
      end
    endcase
  end

  assign v_c[0] = bus.in_valid;
  assign c_c[0] = cin;
  assign a_c[0] = bus.in_a;
  assign b_c[0] = b_eff;
  assign s_c[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_seg #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_seg (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .flush    (bus.flush),
      .in_valid (v_c[k]),
      .in_a     (a_c[k]),
      .in_b     (b_c[k]),
      .in_sum   (s_c[k]),
      .in_carry (c_c[k]),
      .valid    (v_c[k+1]),
      .a        (a_c[k+1]),
      .b        (b_c[k+1]),
      .sum      (s_c[k+1]),
      .carry    (c_c[k+1])
    );
  end

  assign bus.out_valid = v_c[STAGES];
  assign bus.out_sum   = s_c[STAGES];
  assign bus.out_carry = c_c[STAGES];

  // a^b^sum at the MSB recovers the carry into the MSB from the final registers.
  assign bus.out_ovf  = a_c[STAGES][WIDTH-1] ^ b_c[STAGES][WIDTH-1] ^
                        s_c[STAGES][WIDTH-1] ^ c_c[STAGES];

  // Gated by valid so the flag reads 0 out of reset while the sum is 0.
  assign bus.out_zero = v_c[STAGES] && (s_c[STAGES] == '0);

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder -- drives identical stimulus into three pipe_adder instances
// (STAGES = 1, 2, 4; WIDTH = 32) and compares every output each cycle against
// a queue-based reference model of in-flight operations.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, flush, out_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   mode;

  int tests = 0;
  int fails = 0;
  int stg [3] = '{1, 2, 4};

  // Clock generation
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus1 ();
  pipe_adder_if #(.WIDTH(W)) bus2 ();
  pipe_adder_if #(.WIDTH(W)) bus4 ();

  pipe_adder #(.WIDTH(W), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_adder #(.WIDTH(W), .STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  pipe_adder #(.WIDTH(W), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic         o_valid [3];
  logic         o_ready [3];
  logic [W-1:0] o_sum   [3];
  logic         o_carry [3];
  logic         o_ovf   [3];
  logic         o_zero  [3];

  assign o_valid[0] = bus1.out_valid;  assign o_valid[1] = bus2.out_valid;  assign o_valid[2] = bus4.out_valid;
  assign o_ready[0] = bus1.in_ready;   assign o_ready[1] = bus2.in_ready;   assign o_ready[2] = bus4.in_ready;
  assign o_sum[0]   = bus1.out_sum;    assign o_sum[1]   = bus2.out_sum;    assign o_sum[2]   = bus4.out_sum;
  assign o_carry[0] = bus1.out_carry;  assign o_carry[1] = bus2.out_carry;  assign o_carry[2] = bus4.out_carry;
  assign o_ovf[0]   = bus1.out_ovf;    assign o_ovf[1]   = bus2.out_ovf;    assign o_ovf[2]   = bus4.out_ovf;
  assign o_zero[0]  = bus1.out_zero;   assign o_zero[1]  = bus2.out_zero;   assign o_zero[2]  = bus4.out_zero;

  // Reference model: one queue of in-flight operations for all three DUTs.
  // age = cycles the operation has spent inside its DUT; it is presented
  // at the output once age reaches that DUT's STAGES.
  typedef struct {
    int           d;
    int           age;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
  } item_t;

  item_t q [$];

  function automatic item_t ref_op(int d, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] m);
    item_t        r;
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   full;
    case (m)
      2'd1:    begin bb = ~b;     ci = 1'b1; end
      2'd2:    begin bb = b << 2; ci = 1'b0; end
      default: begin bb = b;      ci = 1'b0; end
    endcase
    full    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    r.d     = d;
    r.age   = 1;
    r.sum   = full[W-1:0];
    r.carry = full[W];
    r.ovf   = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    r.zero  = (r.sum == '0);
    return r;
  endfunction

  function automatic int front_idx(int d);
    for (int i = 0; i < q.size(); i++) if (q[i].d == d) return i;
    return -1;
  endfunction

  function automatic bit model_valid(int d);
    int i;
    i = front_idx(d);
    return (i >= 0) && (q[i].age == stg[d]);
  endfunction

  // Single comparison point
  task automatic check(string tag, int d, logic [W-1:0] obs, logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s (STAGES=%0d): got %h, expected %h", tag, stg[d], obs, exp);
    end
  endtask

  // Drive the same inputs into every DUT
  task automatic applyStimulus(logic v, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] m,
                               logic f, logic r);
    in_valid = v; in_a = a; in_b = b; mode = m; flush = f; out_ready = r;
    bus1.in_valid = v; bus1.in_a = a; bus1.in_b = b; bus1.mode = m; bus1.flush = f; bus1.out_ready = r;
    bus2.in_valid = v; bus2.in_a = a; bus2.in_b = b; bus2.mode = m; bus2.flush = f; bus2.out_ready = r;
    bus4.in_valid = v; bus4.in_a = a; bus4.in_b = b; bus4.mode = m; bus4.flush = f; bus4.out_ready = r;
  endtask

  // Compare all DUTs against the model for the current cycle
  task automatic checkOutput();
    int  i;
    bit  mv;
    for (int d = 0; d < 3; d++) begin
      mv = model_valid(d);
      check("out_valid", d, o_valid[d], mv);
      check("in_ready", d, o_ready[d], !mv || out_ready);
      if (mv) begin
        i = front_idx(d);
        check("out_sum",   d, o_sum[d],   q[i].sum);
        check("out_carry", d, o_carry[d], q[i].carry);
        check("out_ovf",   d, o_ovf[d],   q[i].ovf);
        check("out_zero",  d, o_zero[d],  q[i].zero);
      end
    end
  endtask

  task automatic checkReset();
    for (int d = 0; d < 3; d++) begin
      check("rst out_valid", d, o_valid[d], 1'b0);
      check("rst out_sum",   d, o_sum[d],   '0);
      check("rst out_carry", d, o_carry[d], 1'b0);
      check("rst out_ovf",   d, o_ovf[d],   1'b0);
      check("rst out_zero",  d, o_zero[d],  1'b0);
    end
  endtask

  // One clock cycle: check before the edge, then advance the model across it.
  task automatic cycle();
    bit adv [3];
    #1;
    checkOutput();
    for (int d = 0; d < 3; d++) adv[d] = !model_valid(d) || out_ready;
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (adv[d]) begin
          for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].d == d) begin
              if (q[i].age == stg[d]) q.delete(i);
              else q[i].age++;
            end
          end
          if (in_valid) q.push_back(ref_op(d, in_a, in_b, mode));
        end
      end
    end
    #1;
  endtask

  logic [W-1:0] da [5] = '{32'h00400004, 32'h00000005, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h12345678};
  logic [W-1:0] db [5] = '{32'hFFFFFFFF, 32'h00000005, 32'h00000001, 32'h00000001, 32'h00000000};
  logic [1:0]   dm [5] = '{2'd2,         2'd1,         2'd0,         2'd0,         2'd3};

  initial begin
    int           n;
    logic [W-1:0] ca, cb;
    logic [1:0]   cm;

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    #2;
    checkReset();
    cycle();
    cycle();
    checkReset();
    rst_n = 1'b1;

    // Basic ADD with latency check
    applyStimulus(1'b1, 32'h00400004, 32'h00000010, 2'd0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    repeat (5) cycle();

    // Directed corner cases back to back: SHL2, SUB to zero, overflow, wrap, reserved mode
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, da[k], db[k], dm[k], 1'b0, 1'b1);
      cycle();
    end
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    repeat (5) cycle();

    // Eight back-to-back inputs with the consumer stalled on cycles 3-5
    n  = 0;
    ca = $urandom; cb = $urandom; cm = 2'($urandom_range(0, 3));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(n < 8, ca, cb, cm, 1'b0, !(i >= 3 && i <= 5));
      if (n < 8 && (!model_valid(1) || out_ready)) begin
        cycle();
        n++;
        ca = $urandom; cb = $urandom; cm = 2'($urandom_range(0, 3));
      end else begin
        cycle();
      end
    end
    check("b2b accepted", 1, n, 8);

    // Flush with two operations in flight and a third presented alongside it
    applyStimulus(1'b1, $urandom, $urandom, 2'd0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b1, $urandom, $urandom, 2'd1, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b1, $urandom, $urandom, 2'd2, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    repeat (5) cycle();
    applyStimulus(1'b1, 32'h00400004, 32'h00000010, 2'd0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    repeat (5) cycle();

    // Random traffic with random backpressure and occasional flush
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
      cycle();
    end
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    repeat (6) cycle();

    // Asynchronous reset in the middle of a stream
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, $urandom, $urandom, 2'd0, 1'b0, 1'b1);
      cycle();
    end
    rst_n = 1'b0;
    q.delete();
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    #1;
    checkReset();
    cycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h00400004, 32'h00000010, 2'd0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
